diagv2_test_sequencer: RTL and testbench

Synthesizable hardware successor to the ISA regression harness. Steps the core through NUM_TESTS programs in turn. For each test it holds the core in reset, requests an image load from the external memory loader, releases the core and watches for an ECALL. It then classifies the outcome (pass/fail/bad-call/timeout), gates the core clock and keeps running totals. It sits beside diagv2_top, drives its reset and clock enable, and reads a7/a0 through dedicated taps.

---
 rtl/diagv2_test_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_diagv2_test_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/diagv2_test_sequencer.sv
// Regression sequencer for diagv2_top: loads each test image, runs the core until
// exit ecall, bad call or watchdog expiry, then records the outcome and keeps totals.
module diagv2_test_sequencer #(
    parameter int NUM_TESTS      = 50,
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int EXIT_CALL      = 93,
    parameter int BAD_CALL_MODE  = 0,
    parameter int IW             = $clog2(NUM_TESTS + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            load_req,
    output logic [IW-1:0]   load_idx,
    input  logic            load_done,
    output logic            core_reset,
    output logic            core_clk_en,
    input  logic            ecall,
    input  logic [XLEN-1:0] sys_call,
    input  logic [XLEN-1:0] arg0,
    output logic            result_valid,
    output logic [1:0]      result_status,
    output logic [XLEN-1:0] result_code,
    output logic [IW-1:0]   pass_count,
    output logic [IW-1:0]   fail_count,
    output logic [IW-1:0]   bad_call_count,
    output logic            busy,
    output logic            done
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_TESTS - 1);
    localparam logic [XLEN-1:0] EXIT_ID  = XLEN'(EXIT_CALL);

    localparam logic [1:0] ST_PASS    = 2'd0;
    localparam logic [1:0] ST_FAIL    = 2'd1;
    localparam logic [1:0] ST_BADCALL = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_RECORD, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [WW-1:0]   watchdog, watchdog_n;
    logic            load_req_n, core_reset_n, core_clk_en_n;
    logic [IW-1:0]   load_idx_n, pass_count_n, fail_count_n, bad_call_count_n;
    logic            result_valid_n, busy_n, done_n;
    logic [1:0]      result_status_n;
    logic [XLEN-1:0] result_code_n;

    logic            fin;
    logic [1:0]      fin_status;
    logic [XLEN-1:0] fin_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            watchdog       <= '0;
            load_req       <= 1'b0;
            load_idx       <= '0;
            core_reset     <= 1'b1;
            core_clk_en    <= 1'b0;
            result_valid   <= 1'b0;
            result_status  <= ST_PASS;
            result_code    <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            bad_call_count <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            watchdog       <= watchdog_n;
            load_req       <= load_req_n;
            load_idx       <= load_idx_n;
            core_reset     <= core_reset_n;
            core_clk_en    <= core_clk_en_n;
            result_valid   <= result_valid_n;
            result_status  <= result_status_n;
            result_code    <= result_code_n;
            pass_count     <= pass_count_n;
            fail_count     <= fail_count_n;
            bad_call_count <= bad_call_count_n;
            busy           <= busy_n;
            done           <= done_n;
        end
    end

    always_comb begin
        state_n          = state;
        watchdog_n       = watchdog;
        load_req_n       = load_req;
        load_idx_n       = load_idx;
        core_reset_n     = core_reset;
        core_clk_en_n    = core_clk_en;
        result_valid_n   = 1'b0;
        result_status_n  = result_status;
        result_code_n    = result_code;
        pass_count_n     = pass_count;
        fail_count_n     = fail_count;
        bad_call_count_n = bad_call_count;
        busy_n           = busy;
        done_n           = done;
        fin              = 1'b0;
        fin_status       = ST_PASS;
        fin_code         = '0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n          = S_LOAD;
                    load_req_n       = 1'b1;
                    load_idx_n       = '0;
                    pass_count_n     = '0;
                    fail_count_n     = '0;
                    bad_call_count_n = '0;
                    busy_n           = 1'b1;
                    done_n           = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    load_req_n = 1'b0;
                    state_n    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                core_reset_n  = 1'b0;
                core_clk_en_n = 1'b1;
                watchdog_n    = '0;
                state_n       = S_RUN;
            end
            S_RUN: begin
                watchdog_n = watchdog + 1'b1;
                if (ecall && sys_call == EXIT_ID) begin
                    fin        = 1'b1;
                    fin_status = (arg0 == '0) ? ST_PASS : ST_FAIL;
                    fin_code   = arg0;
                end else begin
                    // Saturate so a chatty core in ignore mode cannot wrap the count.
                    if (ecall && bad_call_count != '1)
                        bad_call_count_n = bad_call_count + 1'b1;
                    if (ecall && BAD_CALL_MODE == 0) begin
                        fin        = 1'b1;
                        fin_status = ST_BADCALL;
                        fin_code   = arg0;
                    end else if (watchdog == WD_LAST) begin
                        fin        = 1'b1;
                        fin_status = ST_TIMEOUT;
                    end
                end
            end
            S_RECORD: begin
                if (load_idx == LAST_IDX) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n    = S_LOAD;
                    load_idx_n = load_idx + 1'b1;
                    load_req_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Outcome and totals become visible together in the RECORD cycle.
        if (fin) begin
            state_n         = S_RECORD;
            core_clk_en_n   = 1'b0;
            core_reset_n    = 1'b1;
            result_valid_n  = 1'b1;
            result_status_n = fin_status;
            result_code_n   = fin_code;
            if (fin_status == ST_PASS) pass_count_n = pass_count + 1'b1;
            else                       fail_count_n = fail_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// Table-driven plus randomized bench: per-test plans (load delay, ecall timing) are
// scored by a plan-level outcome model and checked cycle by cycle.
module tb_diagv2_test_sequencer;

    localparam int T = 20;
    localparam int N = 4;

    typedef struct {
        int          ld;
        int          kb;
        int          ke;
        logic [63:0] a0;
        logic [1:0]  st;
        logic [63:0] code;
        int          cyc;
    } plan_t;

    int errors = 0;
    int checks = 0;
    int exp_pass, exp_fail, exp_bad;

    logic        clk = 1'b0;
    logic        reset_n, start, load_done, ecall;
    logic [63:0] sys_call, arg0;
    logic        load_req, core_reset, core_clk_en, result_valid, busy, done;
    logic [2:0]  load_idx, pass_count, fail_count, bad_call_count;
    logic [1:0]  result_status;
    logic [63:0] result_code;

    logic        b_start, b_load_done, b_ecall;
    logic [63:0] b_sys_call, b_arg0;
    logic        b_load_req, b_core_reset, b_core_clk_en, b_result_valid, b_busy, b_done;
    logic [0:0]  b_load_idx, b_pass_count, b_fail_count, b_bad_call_count;
    logic [1:0]  b_result_status;
    logic [63:0] b_result_code;

    always #5 clk = ~clk;

    diagv2_test_sequencer #(.NUM_TESTS(N), .XLEN(64), .TIMEOUT_CYCLES(T),
                            .EXIT_CALL(93), .BAD_CALL_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .load_req(load_req),
        .load_idx(load_idx), .load_done(load_done), .core_reset(core_reset),
        .core_clk_en(core_clk_en), .ecall(ecall), .sys_call(sys_call), .arg0(arg0),
        .result_valid(result_valid), .result_status(result_status),
        .result_code(result_code), .pass_count(pass_count), .fail_count(fail_count),
        .bad_call_count(bad_call_count), .busy(busy), .done(done)
    );

    diagv2_test_sequencer #(.NUM_TESTS(1), .XLEN(64), .TIMEOUT_CYCLES(T),
                            .EXIT_CALL(93), .BAD_CALL_MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .load_req(b_load_req),
        .load_idx(b_load_idx), .load_done(b_load_done), .core_reset(b_core_reset),
        .core_clk_en(b_core_clk_en), .ecall(b_ecall), .sys_call(b_sys_call),
        .arg0(b_arg0), .result_valid(b_result_valid),
        .result_status(b_result_status), .result_code(b_result_code),
        .pass_count(b_pass_count), .fail_count(b_fail_count),
        .bad_call_count(b_bad_call_count), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic plan_t mk(int ld, int kb, int ke, logic [63:0] a0,
                                 logic [1:0] st, logic [63:0] code, int cyc);
        plan_t p;
        p.ld = ld; p.kb = kb; p.ke = ke; p.a0 = a0; p.st = st; p.code = code; p.cyc = cyc;
        return p;
    endfunction

    // Outcome of one test from its plan, for the bad-call-fails mode.
    function automatic plan_t model(int ld, int kb, int ke, logic [63:0] a0);
        if (kb != 0 && kb <= T && (ke == 0 || kb < ke)) return mk(ld, kb, ke, a0, 2'd2, a0, kb);
        if (ke != 0 && ke <= T) return mk(ld, kb, ke, a0, (a0 == 0) ? 2'd0 : 2'd1, a0, ke);
        return mk(ld, kb, ke, a0, 2'd3, 64'd0, T);
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        exp_pass = 0; exp_fail = 0; exp_bad = 0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_load_req", load_req, 1);
        chk("start_idx", load_idx, 0);
        chk("start_pass_clr", pass_count, 0);
        chk("start_fail_clr", fail_count, 0);
        chk("start_bad_clr", bad_call_count, 0);
    endtask

    // Entered at a negedge with the sequencer in LOAD for test idx.
    task automatic run_test(input plan_t p, input int idx, input bit poke);
        chk("load_req_hi", load_req, 1);
        chk("load_idx", load_idx, idx);
        for (int d = 0; d < p.ld; d++) begin
            start = poke && (d == 0);
            @(posedge clk); @(negedge clk);
            start = 1'b0;
        end
        if (poke) begin
            chk("busy_start_idx", load_idx, idx);
            chk("busy_start_req", load_req, 1);
            chk("busy_start_pass", pass_count, exp_pass);
        end
        load_done = 1'b1;
        @(posedge clk); @(negedge clk);
        load_done = 1'b0;
        chk("load_req_fall", load_req, 0);
        chk("reset_held_release", core_reset, 1);
        @(posedge clk); @(negedge clk);
        chk("core_reset_fall", core_reset, 0);
        chk("clk_en_rise", core_clk_en, 1);
        for (int c = 1; c <= p.cyc; c++) begin
            ecall    = (c == p.kb) || (c == p.ke);
            sys_call = (c == p.ke) ? 64'd93 : 64'd64;
            arg0     = p.a0;
            @(posedge clk); @(negedge clk);
            ecall = 1'b0;
            if (c < p.cyc) begin
                chk("run_no_result", result_valid, 0);
                chk("run_clk_en", core_clk_en, 1);
            end
        end
        if (p.st == 2'd0) exp_pass++; else exp_fail++;
        if (p.kb != 0 && p.kb <= p.cyc) exp_bad++;
        chk("result_valid", result_valid, 1);
        chk("result_status", result_status, p.st);
        chk("result_code", result_code, p.code);
        chk("record_idx", load_idx, idx);
        chk("pass_count", pass_count, exp_pass);
        chk("fail_count", fail_count, exp_fail);
        chk("bad_call_count", bad_call_count, exp_bad);
        chk("record_halt", core_clk_en, 0);
        chk("record_reset", core_reset, 1);
        @(posedge clk); @(negedge clk);
        chk("result_pulse_end", result_valid, 0);
        chk("status_hold", result_status, p.st);
        if (idx == N - 1) begin
            chk("done_hi", done, 1);
            chk("done_busy", busy, 0);
            chk("done_reset", core_reset, 1);
            chk("done_pass", pass_count, exp_pass);
        end else begin
            chk("next_load_req", load_req, 1);
            chk("next_idx", load_idx, idx + 1);
        end
    endtask

    plan_t tbl [8];

    initial begin
        tbl[0] = mk(3, 0, 5,  64'd0, 2'd0, 64'd0, 5);
        tbl[1] = mk(0, 0, 1,  64'd5, 2'd1, 64'd5, 1);
        tbl[2] = mk(1, 0, 0,  64'd0, 2'd3, 64'd0, T);
        tbl[3] = mk(2, 0, T,  64'd0, 2'd0, 64'd0, T);
        tbl[4] = mk(1, 4, 0,  64'd7, 2'd2, 64'd7, 4);
        tbl[5] = mk(0, 3, 8,  64'd9, 2'd2, 64'd9, 3);
        tbl[6] = mk(2, 9, 2,  64'd0, 2'd0, 64'd0, 2);
        tbl[7] = mk(0, 0, 6,  64'hDEAD_BEEF_0000_0001, 2'd1, 64'hDEAD_BEEF_0000_0001, 6);

        reset_n = 1'b0; start = 1'b0; load_done = 1'b0; ecall = 1'b0;
        sys_call = '0; arg0 = '0;
        b_start = 1'b0; b_load_done = 1'b0; b_ecall = 1'b0; b_sys_call = '0; b_arg0 = '0;
        #12;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_clk_en", core_clk_en, 0);
        chk("rst_load_req", load_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result_valid", result_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req", load_req, 0);

        do_start();
        for (int i = 0; i < 4; i++) run_test(tbl[i], i, i == 2);
        chk("run1_pass", pass_count, 2);
        chk("run1_fail", fail_count, 2);

        do_start();
        for (int i = 4; i < 8; i++) run_test(tbl[i], i - 4, 1'b0);
        chk("run2_fail", fail_count, 3);
        chk("run2_bad", bad_call_count, 2);

        for (int r = 0; r < 5; r++) begin
            do_start();
            for (int i = 0; i < N; i++) begin
                int ld, kb, ke;
                logic [63:0] a0;
                ld = $urandom_range(0, 4);
                kb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T) : 0;
                ke = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, T + 3);
                if (ke == kb) kb = 0;
                a0 = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
                run_test(model(ld, kb, ke, a0), i, 1'b0);
            end
        end

        // Asynchronous reset in the middle of the second test's RUN phase.
        do_start();
        run_test(tbl[1], 0, 1'b0);
        load_done = 1'b1;
        @(posedge clk); @(negedge clk);
        load_done = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_core_reset", core_reset, 1);
        chk("mid_rst_clk_en", core_clk_en, 0);
        chk("mid_rst_fail_count", fail_count, 0);
        chk("mid_rst_code", result_code, 0);
        chk("mid_rst_idx", load_idx, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_req", load_req, 0);
        chk("post_rst_idle_done", done, 0);

        // Ignore-mode instance, single test: bad call then exit(0).
        b_start = 1'b1;
        @(posedge clk); @(negedge clk);
        b_start = 1'b0;
        chk("b_load_req", b_load_req, 1);
        repeat (3) @(negedge clk);
        b_load_done = 1'b1;
        @(posedge clk); @(negedge clk);
        b_load_done = 1'b0;
        chk("b_reset_held", b_core_reset, 1);
        @(posedge clk); @(negedge clk);
        chk("b_reset_fall", b_core_reset, 0);
        for (int c = 1; c <= 6; c++) begin
            b_ecall    = (c == 2) || (c == 6);
            b_sys_call = (c == 6) ? 64'd93 : 64'd64;
            b_arg0     = (c == 6) ? 64'd0 : 64'd3;
            @(posedge clk); @(negedge clk);
            b_ecall = 1'b0;
            if (c >= 2 && c < 6) begin
                chk("b_keeps_running", b_core_clk_en, 1);
                chk("b_no_result", b_result_valid, 0);
            end
        end
        chk("b_result_valid", b_result_valid, 1);
        chk("b_status_pass", b_result_status, 0);
        chk("b_code", b_result_code, 0);
        chk("b_pass", b_pass_count, 1);
        chk("b_fail", b_fail_count, 0);
        chk("b_bad", b_bad_call_count, 1);
        @(negedge clk);
        chk("b_done", b_done, 1);
        chk("b_busy", b_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
